// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, types and helpers for the ADC capture path
package adc_pkg;

  localparam int ADC_RESULT_W = 16;
  localparam int DROP_CNT_W   = 8;

  typedef logic [ADC_RESULT_W-1:0] adc_result_t;
  typedef logic [DROP_CNT_W-1:0]   drop_cnt_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (&v) ? v : v + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/adc_osr_capture_if.sv
// rtl/adc_osr_capture_if.sv - oversampler strobe/data in, result FIFO read and status out
interface adc_osr_capture_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import adc_pkg::*;

  logic                        osr_done_in;
  adc_result_t                 osr_data_in;
  logic                        rd_ready;
  logic                        clear_ovf;
  adc_result_t                 rd_data;
  logic                        rd_valid;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        overflow;
  drop_cnt_t                   drop_count;

  modport master (
    output osr_done_in, osr_data_in, rd_ready, clear_ovf,
    input  rd_data, rd_valid, level, overflow, drop_count
  );

  modport slave (
    input  osr_done_in, osr_data_in, rd_ready, clear_ovf,
    output rd_data, rd_valid, level, overflow, drop_count
  );

endinterface

// File: rtl/adc_strobe_sync.sv
// rtl/adc_strobe_sync.sv - synchronizer and rising-edge pulse for the conversion strobe
module adc_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_in,
  output logic capture
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Resynchronize the strobe, keep its previous value, and flag a single-cycle 0->1 capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      capture <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      edge_q  <= sync_q[SYNC_STAGES-1];
      capture <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

endmodule

// File: rtl/adc_osr_capture.sv
// rtl/adc_osr_capture.sv - captures oversampler results into a registered FIFO with overflow tracking
module adc_osr_capture
  import adc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  adc_osr_capture_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic             cap_pulse;
  adc_result_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_eff;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             rd_valid_q;
  adc_result_t      rd_data_q;
  logic             overflow_q;
  drop_cnt_t        drop_cnt_q;

  adc_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_in(bus.osr_done_in),
    .capture  (cap_pulse)
  );

  // A full FIFO still accepts a capture when the head leaves in the same cycle
  always_comb begin
    full       = (level_q == LVL_W'(FIFO_DEPTH));
    pop        = rd_valid_q & bus.rd_ready;
    push       = cap_pulse & (~full | pop);
    drop       = cap_pulse & full & ~pop;
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    level_eff  = level_q - LVL_W'(pop);
  end

  // Result storage; every read is qualified by level, so contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.osr_data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level carries full/empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Registered head: only entries already stored before this cycle are presented, so a new entry shows a cycle after its write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= (level_eff != '0);
      rd_data_q  <= (level_eff != '0) ? mem[rd_ptr_nxt] : '0;
    end
  end

  // Sticky overflow and saturating drop count; a drop coinciding with a clear counts as the first new drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_cnt_q <= bus.clear_ovf ? drop_cnt_t'(1) : sat_inc(drop_cnt_q);
    end else if (bus.clear_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_adc_osr_capture.sv
// tb/tb_adc_osr_capture.sv - directed and randomized checks of adc_osr_capture against a queue model
module tb_adc_osr_capture;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  adc_osr_capture_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  adc_osr_capture #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1);
  end

  // Reference model: stored results with the clock edge each was written on,
  // pending capture edges, and status counters.
  logic [15:0] mq_d [$];
  int          mq_t [$];
  int          sched [$];
  int          edge_n = 0;
  logic        st_prev = 1'b0;
  logic        vis_m = 1'b0;
  logic        ovf_m = 1'b0;
  int          cnt_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    mq_d.delete();
    mq_t.delete();
    sched.delete();
    st_prev = 1'b0;
    vis_m   = 1'b0;
    ovf_m   = 1'b0;
    cnt_m   = 0;
  endtask

  // One clock: update the model from the inputs the DUT sampled, then compare all outputs
  task automatic tick();
    logic pop_m;
    logic drop_m;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_clear();
    end else begin
      pop_m  = vis_m && bus.rd_ready;
      drop_m = 1'b0;
      if (pop_m) begin
        void'(mq_d.pop_front());
        void'(mq_t.pop_front());
      end
      if (bus.osr_done_in && !st_prev) sched.push_back(edge_n + SYNC_STAGES + 1);
      st_prev = bus.osr_done_in;
      if (sched.size() > 0 && sched[0] == edge_n) begin
        void'(sched.pop_front());
        if (mq_d.size() < FIFO_DEPTH) begin
          mq_d.push_back(bus.osr_data_in);
          mq_t.push_back(edge_n);
        end else begin
          drop_m = 1'b1;
        end
      end
      if (drop_m) begin
        ovf_m = 1'b1;
        cnt_m = bus.clear_ovf ? 1 : ((cnt_m == 255) ? 255 : cnt_m + 1);
      end else if (bus.clear_ovf) begin
        ovf_m = 1'b0;
        cnt_m = 0;
      end
      vis_m = (mq_d.size() > 0) && (mq_t[0] < edge_n);
    end
    #1;
    check_eq("level", 32'(bus.level), mq_d.size());
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(vis_m));
    check_eq("overflow", 32'(bus.overflow), 32'(ovf_m));
    check_eq("drop_count", 32'(bus.drop_count), cnt_m);
    if (vis_m) check_eq("rd_data", 32'(bus.rd_data), 32'(mq_d[0]));
    else if (mq_d.size() == 0) check_eq("rd_data_empty", 32'(bus.rd_data), 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [15:0] d, input int hi, input int lo);
    bus.osr_data_in = d;
    bus.osr_done_in = 1'b1;
    run(hi);
    bus.osr_done_in = 1'b0;
    run(lo);
  endtask

  initial begin
    logic [15:0] exp4 [4];
    int rise;
    int hi_left;
    int lo_left;
    int ready_pct;

    rst             = 1'b1;
    bus.osr_done_in = 1'b0;
    bus.osr_data_in = 16'h0000;
    bus.rd_ready    = 1'b0;
    bus.clear_ovf   = 1'b0;
    run(3);
    check_eq("rst_level", 32'(bus.level), 0);
    check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("rst_rd_data", 32'(bus.rd_data), 0);
    check_eq("rst_overflow", 32'(bus.overflow), 0);
    check_eq("rst_drop_count", 32'(bus.drop_count), 0);
    rst = 1'b0;
    run(2);

    // Single strobe with the consumer always ready: latency from first high sample
    rise = -1;
    bus.rd_ready    = 1'b1;
    bus.osr_data_in = 16'hABC0;
    bus.osr_done_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) bus.osr_done_in = 1'b0;
      tick();
      if (rise < 0 && bus.rd_valid) begin
        rise = i;
        check_eq("lat_data", 32'(bus.rd_data), 32'h0000_ABC0);
      end
    end
    check_eq("lat_cycles", rise - 1, SYNC_STAGES + 2);
    check_eq("lat_level", 32'(bus.level), 0);

    // Five strobes into a four-deep FIFO with no reads
    bus.rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(16'(i * 16), 2, 2);
    run(SYNC_STAGES + 3);
    check_eq("ovf5_level", 32'(bus.level), 4);
    check_eq("ovf5_overflow", 32'(bus.overflow), 1);
    check_eq("ovf5_drops", 32'(bus.drop_count), 1);
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovf5_order", 32'(bus.rd_data), i * 16);
      tick();
    end
    check_eq("ovf5_drained", 32'(bus.rd_valid), 0);
    bus.rd_ready = 1'b0;

    // Full FIFO with a capture landing exactly on a pop
    bus.clear_ovf = 1'b1;
    run(1);
    bus.clear_ovf = 1'b0;
    for (int i = 1; i <= 4; i++) strobe(16'(i * 256), 2, 2);
    run(SYNC_STAGES + 3);
    bus.osr_data_in = 16'h0500;
    bus.osr_done_in = 1'b1;
    run(SYNC_STAGES + 1);
    bus.rd_ready = 1'b1;
    run(1);
    bus.rd_ready    = 1'b0;
    bus.osr_done_in = 1'b0;
    run(4);
    check_eq("fullpop_level", 32'(bus.level), 4);
    check_eq("fullpop_drops", 32'(bus.drop_count), 0);
    check_eq("fullpop_overflow", 32'(bus.overflow), 0);
    exp4[0] = 16'h0200;
    exp4[1] = 16'h0300;
    exp4[2] = 16'h0400;
    exp4[3] = 16'h0500;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("fullpop_order", 32'(bus.rd_data), 32'(exp4[i]));
      tick();
    end
    bus.rd_ready = 1'b0;

    // 300 strobes with no reads saturate the drop counter; then clear collides with a drop
    for (int i = 0; i < 300; i++) strobe(16'(i), 2, 2);
    run(SYNC_STAGES + 2);
    check_eq("sat_drops", 32'(bus.drop_count), 255);
    check_eq("sat_overflow", 32'(bus.overflow), 1);
    bus.osr_data_in = 16'h7777;
    bus.osr_done_in = 1'b1;
    run(SYNC_STAGES + 1);
    bus.clear_ovf = 1'b1;
    run(1);
    bus.clear_ovf = 1'b0;
    check_eq("clrdrop_overflow", 32'(bus.overflow), 1);
    check_eq("clrdrop_drops", 32'(bus.drop_count), 1);
    bus.osr_done_in = 1'b0;
    run(3);

    // Reset with three entries stored and the strobe high
    bus.rd_ready = 1'b1;
    run(FIFO_DEPTH + 2);
    bus.rd_ready = 1'b0;
    for (int i = 1; i <= 3; i++) strobe(16'(16'h1000 + i), 2, 2);
    run(SYNC_STAGES + 3);
    check_eq("pre_rst_level", 32'(bus.level), 3);
    bus.osr_data_in = 16'h0BAD;
    bus.osr_done_in = 1'b1;
    run(2);
    rst = 1'b1;
    model_clear();
    #1;
    check_eq("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("mid_rst_level", 32'(bus.level), 0);
    check_eq("mid_rst_rd_data", 32'(bus.rd_data), 0);
    run(3);
    rst = 1'b0;
    run(SYNC_STAGES + 1);
    check_eq("post_rst_before", 32'(bus.level), 0);
    run(1);
    check_eq("post_rst_capture", 32'(bus.level), 1);
    bus.osr_done_in = 1'b0;
    run(4);

    // Strobe held high for 50 cycles yields one entry
    bus.rd_ready = 1'b1;
    run(FIFO_DEPTH + 2);
    bus.rd_ready = 1'b0;
    check_eq("long_empty", 32'(bus.level), 0);
    bus.osr_data_in = 16'h5A5A;
    bus.osr_done_in = 1'b1;
    run(50);
    bus.osr_done_in = 1'b0;
    run(SYNC_STAGES + 4);
    check_eq("long_one_entry", 32'(bus.level), 1);
    bus.rd_ready = 1'b1;
    run(3);

    // Randomized strobes, consumer readiness and clears against the model
    bus.osr_done_in = 1'b0;
    hi_left = 0;
    lo_left = SYNC_STAGES;
    for (int c = 0; c < 3000; c++) begin
      ready_pct     = ((c / 500) % 2 == 0) ? 30 : 85;
      bus.rd_ready  = ($urandom_range(0, 99) < 32'(ready_pct));
      bus.clear_ovf = ($urandom_range(0, 99) < 2);
      if (bus.osr_done_in) begin
        if (hi_left == 0) begin
          bus.osr_done_in = 1'b0;
          lo_left = int'($urandom_range(SYNC_STAGES, SYNC_STAGES + 6));
        end else begin
          hi_left--;
        end
      end else begin
        if (lo_left == 0) begin
          bus.osr_data_in = 16'($urandom);
          bus.osr_done_in = 1'b1;
          hi_left = int'($urandom_range(1, 7));
        end else begin
          lo_left--;
        end
      end
      tick();
    end
    bus.osr_done_in = 1'b0;
    bus.clear_ovf   = 1'b0;
    bus.rd_ready    = 1'b1;
    run(2 * FIFO_DEPTH + SYNC_STAGES + 6);
    check_eq("final_level", 32'(bus.level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_osr_capture.md
ADC_OSR_CAPTURE -- requirements
Module: adc_osr_capture

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 16-bit result entries buffered; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on the strobe input; legal values are 2 or 3.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 osr_done_in  input  1  oversampler conversion-finished strobe, asynchronous to clk.
REQ-006 osr_data_in  input  16  oversampler result; stable from the osr_done_in rising edge until the next one.
REQ-007 rd_ready  input  1  consumer accepts the head entry.
REQ-008 clear_ovf  input  1  single-cycle request to clear overflow and drop_count.
REQ-009 rd_data  output  16  FIFO head entry.
REQ-010 rd_valid  output  1  rd_data holds a valid entry.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  current number of stored entries.
REQ-012 overflow  output  1  sticky flag: at least one result was dropped.
REQ-013 drop_count  output  8  saturating count of dropped results.

Function
REQ-014 osr_done_in SHALL pass through SYNC_STAGES flops, then one edge flop; a capture pulse SHALL assert for one clk cycle when the synchronized value is 1 and the edge flop holds 0.
REQ-015 Capture pulse latency SHALL be SYNC_STAGES+1 clk cycles after the first clk edge that samples osr_done_in high; a strobe high for fewer than two clk periods is not guaranteed to be captured.
REQ-016 osr_data_in SHALL be sampled in the capture-pulse cycle and pushed into the FIFO when level < FIFO_DEPTH.
REQ-017 A strobe held high for many cycles SHALL produce exactly one capture pulse.
REQ-018 The FIFO SHALL be registered, with no fall-through: an entry pushed into an empty FIFO SHALL raise rd_valid on the following cycle.
REQ-019 A pop SHALL occur on every cycle with rd_valid and rd_ready both high; rd_data SHALL show the next entry, or rd_valid SHALL fall, on the following cycle.
REQ-020 rd_data SHALL hold its value while rd_valid is high and rd_ready is low.
REQ-021 A push and a pop in the same cycle SHALL both take effect, leaving level unchanged, including when the FIFO is full.
REQ-022 A capture pulse while the FIFO is full and no pop occurs SHALL discard the sample, set overflow, and increment drop_count, which saturates at 255.
REQ-023 clear_ovf SHALL clear overflow and drop_count on the next cycle; if a drop occurs in the same cycle, overflow SHALL be 1 and drop_count SHALL be 1.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from level, which ranges from 0 to FIFO_DEPTH.
REQ-025 rd_ready while rd_valid is low SHALL have no effect.

Reset
REQ-026 Asserting rst SHALL immediately clear the synchronizer and edge flops, pointers, level, overflow and drop_count; rd_valid SHALL be 0 and rd_data SHALL be 16'h0000.
REQ-027 Reset mid-operation SHALL discard all buffered entries; a strobe already high at deassertion SHALL be seen as a rising edge SYNC_STAGES+1 cycles later.
REQ-028 FIFO storage memory SHALL need no reset; rd_data SHALL be forced to 0 while the FIFO is empty after reset.

Structure
REQ-029 A shared package adc_pkg SHALL hold ADC_RESULT_W = 16 and DROP_CNT_W = 8.
REQ-030 The synchronizer plus edge detector SHALL be a sub-module named adc_strobe_sync, parameterized by SYNC_STAGES.
REQ-031 The FIFO SHALL be inline; the total RTL size is targeted at 150-300 lines.

Verification
REQ-032 One strobe with osr_data_in=16'hABC0, then rd_ready held high -> rd_valid rises exactly SYNC_STAGES+2 cycles after the first high sample, rd_data=16'hABC0, level returns to 0.
REQ-033 Five strobes (16'h0010..16'h0050) with rd_ready=0, FIFO_DEPTH=4 -> level=4, overflow=1, drop_count=1; the reads that follow return 16'h0010..16'h0040 in order.
REQ-034 FIFO full, with a capture pulse coinciding with a pop -> level stays 4, no drop, and the new value appears last in read order.
REQ-035 300 strobes with rd_ready=0 -> drop_count saturates at 255; clear_ovf in the same cycle as another drop -> overflow=1, drop_count=1.
REQ-036 rst asserted with 3 entries stored and the strobe high -> rd_valid=0 and level=0 immediately; after release, one capture occurs SYNC_STAGES+1 cycles later.
REQ-037 Strobe held high for 50 cycles -> exactly one entry captured; random rd_ready against a scoreboard -> in-order data, with no loss unless overflow is set.
